// File: rtl/iter_2d.sv
// iter_2d: row-major (x, y) raster iterator with per-axis last flags, frame done and wrap pulse.
// Define ITER_2D_ONE_SHOT_EN to stop at the final position instead of wrapping to (0, 0).
module iter_2d #(
  parameter int unsigned X_MAX_VALUE = 639,
  parameter int unsigned Y_MAX_VALUE = 479,
  parameter int unsigned X_WIDTH     = $clog2(X_MAX_VALUE + 1),
  parameter int unsigned Y_WIDTH     = $clog2(Y_MAX_VALUE + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic               next,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               x_last,
  output logic               y_last,
  output logic               done,
  output logic               wrapped
);

  localparam logic [X_WIDTH-1:0] XMAX = X_WIDTH'(X_MAX_VALUE);
  localparam logic [Y_WIDTH-1:0] YMAX = Y_WIDTH'(Y_MAX_VALUE);

  logic [X_WIDTH-1:0] x_q, x_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic               x_last_q, x_last_d;
  logic               y_last_q, y_last_d;
  logic               done_q, done_d;
  logic               wrapped_q, wrapped_d;

  // Compare against the maximum before incrementing so non power-of-two ranges never overflow.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    wrapped_d = 1'b0;
    if (init) begin
      x_d = '0;
      y_d = '0;
    end else if (next) begin
      if (x_q != XMAX) begin
        x_d = x_q + 1'b1;
      end else if (y_q != YMAX) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
`ifdef ITER_2D_ONE_SHOT_EN
        x_d = x_q;
        y_d = y_q;
`else
        x_d       = '0;
        y_d       = '0;
        wrapped_d = 1'b1;
`endif
      end
    end
  end

  // Flags derive from the next position so they line up with x/y in the same cycle.
  always_comb begin
    x_last_d = (x_d == XMAX);
    y_last_d = (y_d == YMAX);
    done_d   = x_last_d && y_last_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      x_last_q  <= 1'b0;
      y_last_q  <= 1'b0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      x_last_q  <= x_last_d;
      y_last_q  <= y_last_d;
      done_q    <= done_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign x_last  = x_last_q;
  assign y_last  = y_last_q;
  assign done    = done_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_iter_2d.sv
// Scoreboard bench for iter_2d on a 4x3 raster: directed walk-through followed by random stimulus.
module tb_iter_2d;

  localparam int unsigned XM   = 3;
  localparam int unsigned YM   = 2;
  localparam int unsigned NPOS = (XM + 1) * (YM + 1);

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic       xl;
    logic       yl;
    logic       dn;
    logic       wr;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init = 1'b0;
  logic       next = 1'b0;
  logic [1:0] x;
  logic [1:0] y;
  logic       x_last, y_last, done, wrapped;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  obs_t        sb_q[$];
  int unsigned pos = 0;
  bit          wr  = 1'b0;

  iter_2d #(.X_MAX_VALUE(XM), .Y_MAX_VALUE(YM)) dut (
    .clk(clk), .reset(reset), .init(init), .next(next),
    .x(x), .y(y), .x_last(x_last), .y_last(y_last), .done(done), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  // Reference: a linear frame index; coordinates and flags follow from division and modulo.
  function automatic obs_t model_out();
    obs_t o;
    int unsigned cx, cy;
    cx   = pos % (XM + 1);
    cy   = pos / (XM + 1);
    o.x  = 2'(cx);
    o.y  = 2'(cy);
    o.xl = (cx == XM);
    o.yl = (cy == YM);
    o.dn = (pos == NPOS - 1);
    o.wr = wr;
    return o;
  endfunction

  task automatic model_step(input bit r, input bit i, input bit n);
    wr = 1'b0;
    if (r || i) begin
      pos = 0;
    end else if (n) begin
      if (pos == NPOS - 1) begin
`ifndef ITER_2D_ONE_SHOT_EN
        pos = 0;
        wr  = 1'b1;
`endif
      end else begin
        pos = pos + 1;
      end
    end
  endtask

  task automatic drive(input bit r, input bit i, input bit n);
    @(negedge clk);
    reset = r;
    init  = i;
    next  = n;
    model_step(r, i, n);
    sb_q.push_back(model_out());
  endtask

  task automatic steps(input int unsigned cnt);
    for (int k = 0; k < int'(cnt); k++) drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int unsigned cnt);
    for (int k = 0; k < int'(cnt); k++) drive(1'b0, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    obs_t e, a;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = {x, y, x_last, y_last, done, wrapped};
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL state t=%0t: got x=%0d y=%0d xl=%b yl=%b done=%b wr=%b, want x=%0d y=%0d xl=%b yl=%b done=%b wr=%b",
                 $time, a.x, a.y, a.xl, a.yl, a.dn, a.wr, e.x, e.y, e.xl, e.yl, e.dn, e.wr);
      end
    end
  end

  initial begin
    int unsigned guard;
    drive(1'b1, 1'b0, 1'b0);
    idle(2);
    steps(3);                    // (3,0) with x_last
    steps(1);                    // (0,1)
    drive(1'b0, 1'b1, 1'b0);     // restart
    steps(11);                   // full frame to (3,2)
    steps(1);                    // wrap or hold at final position
    idle(2);
    drive(1'b0, 1'b1, 1'b0);
    steps(6);                    // (2,1)
    drive(1'b0, 1'b1, 1'b1);     // init beats next
    steps(6);
    drive(1'b1, 1'b1, 1'b1);     // reset mid-frame
    steps(9);                    // (1,2)
    idle(5);
    steps(20);                   // wraps twice around the final position
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 7));
    end
    idle(1);
    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (sb_q.size() > 0) begin
      failed++;
      $display("FAIL drain: %0d expected observations left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
